conv_encoder_param: RTL and testbench

- Parametrised, frame-based, feed-forward convolutional encoder with rate 1/2 and constraint length K.
- Generator polynomials are set by parameters.
- Valid/ready streaming interface on input and output.
- Automatic zero-tail termination (K-1 flush bits) at end of frame, returning the trellis to state 0.
- Sits between the bit source and the modulator/channel model; the successor to the fixed K=3 (7,5) encoder.

---
 rtl/conv_encoder_param_if.sv | 24 ++
 rtl/conv_encoder_param.sv | 120 ++++++++++++
 tb/tb_conv_encoder_param.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_encoder_param_if.sv
// Streaming bundle for conv_encoder_param: bit input side, symbol output side, busy flag.
// master drives bits and symbol back-pressure; slave is the encoder.
interface conv_encoder_param_if;
    logic       in_valid;
    logic       in_bit;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_sym;
    logic [1:0] out_mask;
    logic       out_last;
    logic       out_ready;
    logic       busy;

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_sym, out_mask, out_last, busy
    );

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_sym, out_mask, out_last, busy
    );
endinterface

// File: rtl/conv_encoder_param.sv
// Rate-1/2 feed-forward convolutional encoder, constraint length K, zero-tail termination.
// Optional rate-2/3 puncture mask generation when CONV_ENCODER_PUNCTURE_EN is defined.
module conv_encoder_param #(
    parameter int unsigned  K  = 3,
    parameter logic [K-1:0] G0 = 3'o7,
    parameter logic [K-1:0] G1 = 3'o5
) (
    input  logic                 CLK,
    input  logic                 RST,
    conv_encoder_param_if.slave  bus
);
    localparam int unsigned CW = $clog2(K);

    typedef enum logic {ENC, FLUSH} state_t;

    state_t        state, state_next;
    logic [K-2:0]  sr;
    logic [CW-1:0] cnt, cnt_next;
    logic          advance;
    logic          load;
    logic          b;
    logic          last_next;
    logic          in_ready;
    logic [K-1:0]  w;
    logic [1:0]    sym;
    logic          out_valid;
    logic [1:0]    out_sym;
    logic          out_last;
    logic          active;

    always_comb begin
        advance    = !out_valid || bus.out_ready;
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        b          = 1'b0;
        last_next  = 1'b0;
        in_ready   = 1'b0;
        case (state)
            ENC: begin
                in_ready = advance;
                if (bus.in_valid && advance) begin
                    load = 1'b1;
                    b    = bus.in_bit;
                    if (bus.in_last) begin
                        state_next = FLUSH;
                        cnt_next   = CW'(K - 1);
                    end
                end
            end
            FLUSH: begin
                // Tail bits are zeros; after K-1 of them sr is back at state 0.
                if (advance) begin
                    load     = 1'b1;
                    cnt_next = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        last_next  = 1'b1;
                        state_next = ENC;
                    end
                end
            end
            default: ;
        endcase
        w   = {b, sr};
        sym = {^(w & G0), ^(w & G1)};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ENC;
        else     state <= state_next;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sr        <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_last  <= 1'b0;
            active    <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (load) begin
                sr        <= {b, sr[K-2:1]};
                out_valid <= 1'b1;
                out_sym   <= sym;
                out_last  <= last_next;
                active    <= !last_next;
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CONV_ENCODER_PUNCTURE_EN
    logic       phase;
    logic [1:0] out_mask;

    // Mask travels with the symbol it was loaded alongside; phase restarts each frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase    <= 1'b0;
            out_mask <= 2'b11;
        end else if (load) begin
            out_mask <= phase ? 2'b10 : 2'b11;
            phase    <= last_next ? 1'b0 : !phase;
        end
    end

    assign bus.out_mask = out_mask;
`else
    assign bus.out_mask = 2'b11;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sym   = out_sym;
    assign bus.out_last  = out_last;
    assign bus.busy      = active;
endmodule

// File: tb/tb_conv_encoder_param.sv
// Scoreboard bench for conv_encoder_param: K=3 (7,5) and K=7 (171,133) instances.
// Expected symbols are queued at stimulus time; a negedge monitor pops and compares.
module tb_conv_encoder_param;
`ifdef CONV_ENCODER_PUNCTURE_EN
    localparam bit PUNCT = 1'b1;
`else
    localparam bit PUNCT = 1'b0;
`endif

    typedef struct {
        logic [1:0] sym;
        logic [1:0] mask;
        logic       last;
    } exp_t;

    logic CLK;
    logic RST;

    conv_encoder_param_if bus3();
    conv_encoder_param_if bus7();

    conv_encoder_param #(.K(3), .G0(3'o7), .G1(3'o5)) dut3 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus3.slave)
    );

    conv_encoder_param #(.K(7), .G0(7'o171), .G1(7'o133)) dut7 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus7.slave)
    );

    exp_t        q3[$];
    exp_t        q7[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned pops3   = 0;
    int unsigned stall_target = 0;
    bit          stall_req    = 1'b0;
    bit          stalling     = 1'b0;
    int unsigned stall_left   = 0;
    int unsigned stall_cycles = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [1:0] mask_at(input int unsigned idx);
        return (PUNCT && (idx % 2 == 1)) ? 2'b10 : 2'b11;
    endfunction

    task automatic push(input int sel, input logic [1:0] s, input int unsigned idx, input logic l);
        exp_t e;
        e.sym  = s;
        e.mask = mask_at(idx);
        e.last = l;
        if (sel == 3) q3.push_back(e);
        else          q7.push_back(e);
    endtask

    task automatic send_bit(input int sel, input logic b, input logic l);
        bit acc = 1'b0;
        if (sel == 3) begin
            bus3.in_valid = 1'b1; bus3.in_bit = b; bus3.in_last = l;
        end else begin
            bus7.in_valid = 1'b1; bus7.in_bit = b; bus7.in_last = l;
        end
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge CLK);
            if ((sel == 3) ? bus3.in_ready : bus7.in_ready) acc = 1'b1;
            @(posedge CLK);
            #1;
        end
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        if (sel == 3) begin
            bus3.in_valid = 1'b0; bus3.in_bit = 1'b0; bus3.in_last = 1'b0;
        end else begin
            bus7.in_valid = 1'b0; bus7.in_bit = 1'b0; bus7.in_last = 1'b0;
        end
    endtask

    // bits: first bit in bit n-1; exps: first symbol in the top pair of the low 2*(n+2) bits.
    task automatic run_frame3(input logic [7:0] bits, input int unsigned n, input logic [15:0] exps);
        int unsigned ns = n + 2;
        for (int unsigned j = 0; j < ns; j++)
            push(3, exps[2*(ns-j)-1 -: 2], j, j == ns - 1);
        for (int unsigned i = 0; i < n; i++)
            send_bit(3, bits[n-1-i], i == n - 1);
    endtask

    task automatic drain(input int sel, input string name);
        int c = 0;
        while (((sel == 3) ? q3.size() : q7.size()) != 0 && c < 300) begin
            @(posedge CLK);
            #1;
            c++;
        end
        chk(name, (sel == 3) ? q3.size() : q7.size(), 0);
    endtask

    // Back-pressure generator for the K=3 instance.
    initial begin
        bus3.out_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (stalling) begin
                stall_left--;
                if (stall_left == 0) begin
                    stalling = 1'b0;
                    bus3.out_ready = 1'b1;
                end
            end else if (stall_req && bus3.out_valid && pops3 == stall_target) begin
                stalling   = 1'b1;
                stall_left = 3;
                stall_req  = 1'b0;
                bus3.out_ready = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            if (bus3.out_valid) begin
                if (q3.size() == 0) begin
                    chk("k3_unexpected_symbol", 32'd1, 32'd0);
                end else begin
                    chk("k3_sym",  32'(bus3.out_sym),  32'(q3[0].sym));
                    chk("k3_mask", 32'(bus3.out_mask), 32'(q3[0].mask));
                    chk("k3_last", 32'(bus3.out_last), 32'(q3[0].last));
                    if (bus3.out_ready) begin
                        void'(q3.pop_front());
                        pops3++;
                    end
                end
                if (stalling && !bus3.out_ready) begin
                    stall_cycles++;
                    chk("stall_in_ready", 32'(bus3.in_ready), 32'd0);
                end
            end
            if (bus7.out_valid) begin
                if (q7.size() == 0) begin
                    chk("k7_unexpected_symbol", 32'd1, 32'd0);
                end else begin
                    chk("k7_sym",  32'(bus7.out_sym),  32'(q7[0].sym));
                    chk("k7_mask", 32'(bus7.out_mask), 32'(q7[0].mask));
                    chk("k7_last", 32'(bus7.out_last), 32'(q7[0].last));
                    if (bus7.out_ready) void'(q7.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  g0v;
        logic [6:0]  g1v;
        logic [19:0] data7;
        logic        s7[0:25];
        logic        p0;
        logic        p1;

        RST = 1'b1;
        bus3.in_valid = 1'b0; bus3.in_bit = 1'b0; bus3.in_last = 1'b0;
        bus7.in_valid = 1'b0; bus7.in_bit = 1'b0; bus7.in_last = 1'b0;
        bus7.out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out_valid", 32'(bus3.out_valid), 32'd0);
        chk("rst_out_sym",   32'(bus3.out_sym),   32'd0);
        chk("rst_out_mask",  32'(bus3.out_mask),  32'd3);
        chk("rst_out_last",  32'(bus3.out_last),  32'd0);
        chk("rst_busy",      32'(bus3.busy),      32'd0);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_in_ready", 32'(bus3.in_ready), 32'd1);
        @(posedge CLK);
        #1;

        // Frame 1,0,1,1 -> 11,10,00,01,01,11
        run_frame3(8'b1011, 4, 16'hE17);
        drain(3, "drain_frame1");
        chk("idle_busy", 32'(bus3.busy), 32'd0);

        // Same frame with a 3-cycle stall on symbol 2
        stall_target = pops3 + 1;
        stall_req    = 1'b1;
        run_frame3(8'b1011, 4, 16'hE17);
        drain(3, "drain_stall");
        chk("stall_len", stall_cycles, 3);

        // Single-bit frame, then a frame that must start from state 0
        run_frame3(8'b1, 1, 16'h3B);
        run_frame3(8'b01, 2, 16'h3B);
        drain(3, "drain_single");

        // Reset pulsed mid-flush discards the remaining tail
        run_frame3(8'b1011, 4, 16'hE17);
        @(posedge CLK);
        #1;
        chk("pre_rst_busy", 32'(bus3.busy), 32'd1);
        #1 RST = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus3.out_valid), 32'd0);
        chk("midrst_out_sym",   32'(bus3.out_sym),   32'd0);
        chk("midrst_out_mask",  32'(bus3.out_mask),  32'd3);
        chk("midrst_busy",      32'(bus3.busy),      32'd0);
        q3.delete();
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("postrst_in_ready", 32'(bus3.in_ready), 32'd1);
        @(posedge CLK);
        #1;
        run_frame3(8'b1, 1, 16'h3B);
        drain(3, "drain_postrst");

        // in_last without in_valid must not start a flush
        bus3.in_last = 1'b1;
        bus3.in_bit  = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("stray_last_busy",  32'(bus3.busy),      32'd0);
        chk("stray_last_valid", 32'(bus3.out_valid), 32'd0);
        bus3.in_last = 1'b0;
        bus3.in_bit  = 1'b0;
        run_frame3(8'b1, 1, 16'h3B);
        drain(3, "drain_stray");

        // K=7 (171,133), 20-bit frame against a tap-sum reference
        g0v   = 7'o171;
        g1v   = 7'o133;
        data7 = 20'b1011_0010_1110_0011_0101;
        for (int t = 0; t < 26; t++) s7[t] = (t < 20) ? data7[19-t] : 1'b0;
        for (int t = 0; t < 26; t++) begin
            p0 = 1'b0;
            p1 = 1'b0;
            for (int i = 0; i < 7; i++) begin
                if (t >= i) begin
                    p0 = p0 ^ (g0v[6-i] & s7[t-i]);
                    p1 = p1 ^ (g1v[6-i] & s7[t-i]);
                end
            end
            push(7, {p0, p1}, t, t == 25);
        end
        for (int i = 0; i < 20; i++) send_bit(7, s7[i], i == 19);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            chk("k7_flush_in_ready", 32'(bus7.in_ready), 32'd0);
            chk("k7_flush_busy",     32'(bus7.busy),     32'd1);
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        chk("k7_after_in_ready", 32'(bus7.in_ready), 32'd1);
        chk("k7_after_busy",     32'(bus7.busy),     32'd0);
        drain(7, "drain_k7");

        repeat (2) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
